// File: rtl/mioc_od_pkg.sv
// Shared definitions for open-drain receivers: FSM state encoding and default timing.
package mioc_od_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    RSTW = 2'd3
  } od_state_e;

  localparam int FILT_LEN_DEF = 3;
  localparam int T_BIT_DEF    = 8;
  localparam int T_RST_DEF    = 48;
  localparam int T_IDLE_DEF   = 64;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mioc_od_filt.sv
// Two-flop synchronizer followed by a glitch filter: the output follows the
// synchronized line only after FILT_LEN consecutive samples disagree with it.
module mioc_od_filt
  import mioc_od_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic filt_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

  logic          s1_q, s2_q;
  logic          filt_q, filt_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q   <= 1'b1;
      s2_q   <= 1'b1;
      filt_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      s1_q   <= line_i;
      s2_q   <= s1_q;
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  // cnt_q holds how many disagreeing samples preceded the current one
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (s2_q != filt_q) begin
      if (cnt_q == CW'(FILT_LEN - 1)) filt_d = s2_q;
      else                            cnt_d  = cnt_q + CW'(1);
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/mioc_od_rx.sv
// Open-drain pulse-width byte receiver with one-entry output buffer.
// Define MIOC_OD_RX_PARITY_EN to expect a 9th odd-parity bit per frame.
module mioc_od_rx
  import mioc_od_pkg::*;
#(
  parameter int FILT_LEN = FILT_LEN_DEF,
  parameter int T_BIT    = T_BIT_DEF,
  parameter int T_RST    = T_RST_DEF,
  parameter int T_IDLE   = T_IDLE_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       line_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       bus_rst,
  output logic       err_ovf,
  output logic       err_frm,
  output logic       err_par,
  output logic       busy
);

  localparam int CNT_MAX = max_int(T_RST, T_IDLE);
  localparam int CW      = $clog2(CNT_MAX + 2);
`ifdef MIOC_OD_RX_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif
  localparam logic [3:0] LAST_BIT = 4'(NBITS - 1);

  logic          filt;
  od_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d, wid;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    sh_q, sh_d;
  logic [7:0]    rx_data_q, rx_data_d;
  logic          rx_valid_q, rx_valid_d;
  logic          bus_rst_q, bus_rst_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_frm_q, err_frm_d;
  logic          err_par_q, err_par_d;
  logic          bit_val, done, hs;
  logic [7:0]    done_byte;

  mioc_od_filt #(.FILT_LEN(FILT_LEN)) u_filt (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (line_in),
    .filt_o (filt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      sh_q       <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      bus_rst_q  <= 1'b0;
      err_ovf_q  <= 1'b0;
      err_frm_q  <= 1'b0;
      err_par_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      sh_q       <= sh_d;
      rx_data_q  <= rx_data_d;
      rx_valid_q <= rx_valid_d;
      bus_rst_q  <= bus_rst_d;
      err_ovf_q  <= err_ovf_d;
      err_frm_q  <= err_frm_d;
      err_par_q  <= err_par_d;
    end
  end

  // wid is the width of the current level including this cycle
  assign wid     = cnt_q + CW'(1);
  assign bit_val = (wid < CW'(T_BIT));
  assign hs      = rx_valid_q && rx_ready;

  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CW'(CNT_MAX)) ? cnt_q : cnt_q + CW'(1);
    bit_cnt_d = bit_cnt_q;
    sh_d      = sh_q;
    bus_rst_d = 1'b0;
    err_frm_d = 1'b0;
    err_par_d = 1'b0;
    done      = 1'b0;
    done_byte = sh_q;

    case (state_q)
      IDLE: begin
        if (!filt) begin
          state_d = LOW;
          cnt_d   = '0;
        end
      end
      LOW: begin
        if (filt) begin
          state_d = HIGH;
          cnt_d   = '0;
          if (bit_cnt_q == LAST_BIT) begin
            bit_cnt_d = '0;
            sh_d      = '0;
`ifdef MIOC_OD_RX_PARITY_EN
            if (^{sh_q, bit_val}) done      = 1'b1;
            else                  err_par_d = 1'b1;
`else
            done_byte = {bit_val, sh_q[6:0]};
            done      = 1'b1;
`endif
          end else begin
            sh_d[bit_cnt_q[2:0]] = bit_val;
            bit_cnt_d            = bit_cnt_q + 4'd1;
          end
        end else if (wid == CW'(T_RST)) begin
          state_d   = RSTW;
          bus_rst_d = 1'b1;
          bit_cnt_d = '0;
          sh_d      = '0;
        end
      end
      HIGH: begin
        if (!filt) begin
          state_d = LOW;
          cnt_d   = '0;
        end else if (wid == CW'(T_IDLE)) begin
          state_d   = IDLE;
          err_frm_d = (bit_cnt_q != 4'd0);
          bit_cnt_d = '0;
          sh_d      = '0;
        end
      end
      RSTW: begin
        if (filt) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A byte completing alongside a handshake replaces the one being consumed
  always_comb begin
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    err_ovf_d  = 1'b0;
    if (done) begin
      if (!rx_valid_q || hs) begin
        rx_data_d  = done_byte;
        rx_valid_d = 1'b1;
      end else begin
        err_ovf_d = 1'b1;
      end
    end else if (hs) begin
      rx_valid_d = 1'b0;
    end
  end

  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;
  assign bus_rst  = bus_rst_q;
  assign err_ovf  = err_ovf_q;
  assign err_frm  = err_frm_q;
  assign err_par  = err_par_q;
  assign busy     = (state_q != IDLE);

endmodule
